// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the core pipeline stages and the hazard/stall controller.
// The master modport is the pipeline side; the slave modport is pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int LOG_REG_CNT = 5,
  parameter int REG_CNT     = 32
);
  logic                   rdy;
  logic                   id_valid;
  logic [LOG_REG_CNT-1:0] id_rs1;
  logic [LOG_REG_CNT-1:0] id_rs2;
  logic                   id_rs1_used;
  logic                   id_rs2_used;
  logic [LOG_REG_CNT-1:0] id_rd;
  logic                   id_rd_write;
  logic                   ex_redirect;
  logic                   mem_req;
  logic                   mem_done;
  logic                   wb_write_reg;
  logic [LOG_REG_CNT-1:0] wb_reg_id;
  logic                   issue;
  logic                   stall_if;
  logic                   stall_id;
  logic                   stall_ex_mem;
  logic                   flush_if;
  logic                   flush_id;
  logic [REG_CNT-1:0]     busy_vec;

  modport master (
    output rdy, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_write,
           ex_redirect, mem_req, mem_done, wb_write_reg, wb_reg_id,
    input  issue, stall_if, stall_id, stall_ex_mem, flush_if, flush_id, busy_vec
  );

  modport slave (
    input  rdy, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_write,
           ex_redirect, mem_req, mem_done, wb_write_reg, wb_reg_id,
    output issue, stall_if, stall_id, stall_ex_mem, flush_if, flush_id, busy_vec
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage core: per-register pending-write
// scoreboard plus the RUN / MEM_WAIT / REFILL sequencing FSM.
//
//   state    | meaning
//   RUN      | normal issue, hazards checked against the scoreboard
//   MEM_WAIT | data access outstanding, whole pipe held except WB
//   REFILL   | fetch refilling after a redirect, ID squashed
module pipeline_ctrl #(
  parameter int LOG_REG_CNT = 5,
  parameter int REG_CNT     = 32,
  parameter int PEND_W      = 2,
  parameter int REFILL_CYC  = 2
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam int CNT_W       = (REFILL_CYC > 2) ? $clog2(REFILL_CYC) : 1;
  localparam int REFILL_LOAD = (REFILL_CYC > 1) ? REFILL_CYC - 1 : 0;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REFILL} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] refill_cnt, refill_cnt_nxt;
  logic [PEND_W-1:0] pend [REG_CNT];
  logic             haz_rs1, haz_rs2, raw;
  logic             issue, stall_fe, stall_ex_mem, flush_if, flush_id;
  logic             inc_en, dec_en;
  logic [REG_CNT-1:0] busy;

  // A single pending write that WB retires this cycle is bypassed by the write-first regfile.
  always_comb begin
    haz_rs1 = bus.id_rs1_used && (bus.id_rs1 != '0) && (pend[bus.id_rs1] != '0) &&
              !((pend[bus.id_rs1] == PEND_ONE) && bus.wb_write_reg && (bus.wb_reg_id == bus.id_rs1));
    haz_rs2 = bus.id_rs2_used && (bus.id_rs2 != '0) && (pend[bus.id_rs2] != '0) &&
              !((pend[bus.id_rs2] == PEND_ONE) && bus.wb_write_reg && (bus.wb_reg_id == bus.id_rs2));
  end

  always_comb begin
    state_nxt      = state;
    refill_cnt_nxt = refill_cnt;
    raw            = 1'b0;
    issue          = 1'b0;
    stall_fe       = 1'b0;
    stall_ex_mem   = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    if (rst) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          raw      = bus.id_valid && !haz_rs1 && !haz_rs2 && !bus.ex_redirect;
          issue    = raw && !bus.mem_req && bus.rdy;
          stall_fe = bus.id_valid && !issue && !bus.ex_redirect;
          flush_if = bus.ex_redirect;
          flush_id = bus.ex_redirect;
          // The MEM access belongs to an older instruction, so it wins the transition.
          if (bus.mem_req) begin
            stall_ex_mem = 1'b1;
            state_nxt    = MEM_WAIT;
          end else if (bus.ex_redirect && (REFILL_CYC > 1)) begin
            state_nxt      = REFILL;
            refill_cnt_nxt = CNT_W'(REFILL_LOAD);
          end
        end
        MEM_WAIT: begin
          stall_fe     = 1'b1;
          stall_ex_mem = !bus.mem_done;
          if (bus.mem_done) state_nxt = RUN;
        end
        REFILL: begin
          flush_id = 1'b1;
          flush_if = bus.ex_redirect;
          if (bus.ex_redirect) begin
            refill_cnt_nxt = CNT_W'(REFILL_LOAD);
          end else if (refill_cnt <= CNT_W'(1)) begin
            state_nxt      = RUN;
            refill_cnt_nxt = '0;
          end else begin
            refill_cnt_nxt = refill_cnt - CNT_W'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      refill_cnt <= '0;
    end else if (bus.rdy) begin
      state      <= state_nxt;
      refill_cnt <= refill_cnt_nxt;
    end
  end

  assign inc_en = issue && bus.id_rd_write && (bus.id_rd != '0);
  assign dec_en = bus.rdy && bus.wb_write_reg && (bus.wb_reg_id != '0);

  assign pend[0] = '0;

  for (genvar i = 1; i < REG_CNT; i++) begin : g_pend
    logic              inc_i, dec_i;
    logic [PEND_W-1:0] cnt_q;

    assign inc_i   = inc_en && (bus.id_rd == LOG_REG_CNT'(i));
    assign dec_i   = dec_en && (bus.wb_reg_id == LOG_REG_CNT'(i));
    assign pend[i] = cnt_q;

    // Over/underflow is a pipeline protocol error: hold the count rather than wrap.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (bus.rdy) begin
        if (inc_i && !dec_i && (cnt_q != PEND_MAX)) cnt_q <= cnt_q + PEND_ONE;
        else if (dec_i && !inc_i && (cnt_q != '0)) cnt_q <= cnt_q - PEND_ONE;
      end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(inc_i && !dec_i && (cnt_q == PEND_MAX)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(dec_i && !inc_i && (cnt_q == '0)));
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < REG_CNT; i++) busy[i] = (pend[i] != '0);
  end

  assign bus.issue        = issue;
  assign bus.stall_if     = stall_fe;
  assign bus.stall_id     = stall_fe;
  assign bus.stall_ex_mem = stall_ex_mem;
  assign bus.flush_if     = flush_if;
  assign bus.flush_id     = flush_id;
  assign bus.busy_vec     = rst ? '0 : busy;
endmodule
